// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment hex codes, anode one-hot constants and scan-decoder states
package seg7_pkg;
    localparam logic [0:15][6:0] SEG_HEX = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN3 = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;
    typedef enum logic {HUNT, TRACK} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low segment pattern to hex value, inverse of the display encoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);
    always_comb begin
        legal = 1'b0;
        value = 4'd0;
        for (int i = 0; i < 16; i++)
            if (seg == SEG_HEX[i]) begin
                legal = 1'b1;
                value = 4'(i);
            end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment scan bus and rebuilds 4-digit frames
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  anode,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        locked,
    output logic        seg_err,
    output logic        scan_err
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    logic [10:0] s1, s2, prev;
    logic [SW-1:0] stab_cnt;
    logic [WW-1:0] wd;
    logic [3:0] seen, newbit;
    logic [3:0][3:0] shadow, merged;
    logic [1:0] slot;
    logic [3:0] an, value;
    logic [6:0] sg;
    logic legal, same, accept, blank, one_hot, store, commit, timeout;
    state_t state;
    seg7_decode u_dec (.seg(sg), .legal(legal), .value(value));
    always_comb begin
        an = s2[10:7];
        sg = s2[6:0];
        same = s2 == prev;
        accept = same && stab_cnt == SW'(STABLE_CYCLES - 2);
        blank = an == AN_BLANK;
        one_hot = an == AN0 || an == AN1 || an == AN2 || an == AN3;
        slot = an == AN0 ? 2'd0 : an == AN1 ? 2'd1 : an == AN2 ? 2'd2 : 2'd3;
        newbit = 4'b0001 << slot;
        merged = shadow;
        merged[slot] = value;
        store = accept && one_hot && legal;
        commit = store && (seen | newbit) == 4'b1111;
        timeout = state == TRACK && wd == WW'(TIMEOUT_CYCLES - 1);
    end
    // Sync regs reset to the idle blank code so the first samples never look like a scan fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
            prev <= '1;
            stab_cnt <= '0;
            wd <= '0;
            seen <= '0;
            shadow <= '0;
            digits <= '0;
            frame_valid <= 1'b0;
            frame_changed <= 1'b0;
            locked <= 1'b0;
            seg_err <= 1'b0;
            scan_err <= 1'b0;
            state <= HUNT;
        end else begin
            s1 <= {anode, seg};
            s2 <= s1;
            prev <= s2;
            stab_cnt <= !same ? '0 : stab_cnt == SW'(STABLE_CYCLES - 1) ? stab_cnt : stab_cnt + 1'b1;
            wd <= (accept && !blank) ? '0 : wd == WW'(TIMEOUT_CYCLES - 1) ? wd : wd + 1'b1;
            frame_valid <= 1'b0;
            frame_changed <= 1'b0;
            seg_err <= accept && one_hot && !legal;
            scan_err <= accept && !blank && !one_hot;
            if (timeout) begin
                state <= HUNT;
                locked <= 1'b0;
                seen <= '0;
            end
            if (store) begin
                shadow <= merged;
                seen <= seen | newbit;
            end
            if (commit) begin
                digits <= merged;
                frame_valid <= 1'b1;
                frame_changed <= state == HUNT || merged != digits;
                seen <= '0;
                state <= TRACK;
                locked <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table-driven dwell vectors plus reset-mid-frame sequence
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [3:0] anode = 4'hF;
    logic [15:0] digits;
    logic frame_valid, frame_changed, locked, seg_err, scan_err;
    int nfv = 0, nfc = 0, nse = 0, nsc = 0;
    int errors = 0, checks = 0;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  sg;
        int          n;
        int          fv;
        int          fc;
        int          se;
        int          sc;
        logic [15:0] dg;
        logic        lk;
    } vec_t;
    vec_t tbl[$];

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .seg(seg), .anode(anode), .digits(digits),
        .frame_valid(frame_valid), .frame_changed(frame_changed), .locked(locked),
        .seg_err(seg_err), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nfv++;
        if (frame_valid && frame_changed) nfc++;
        if (seg_err) nse++;
        if (scan_err) nsc++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] an, input logic [6:0] sg, input int n,
                                input int fv, input int fc, input int se, input int sc,
                                input logic [15:0] dg, input logic lk);
        vec_t r;
        r.an = an; r.sg = sg; r.n = n; r.fv = fv; r.fc = fc; r.se = se; r.sc = sc;
        r.dg = dg; r.lk = lk;
        return r;
    endfunction

    task automatic apply(input vec_t r, input string tag);
        int f0, c0, e0, s0;
        f0 = nfv; c0 = nfc; e0 = nse; s0 = nsc;
        anode = r.an;
        seg = r.sg;
        repeat (r.n) @(negedge clk);
        chk({tag, " frame_valid"}, nfv - f0, r.fv);
        chk({tag, " frame_changed"}, nfc - c0, r.fc);
        chk({tag, " seg_err"}, nse - e0, r.se);
        chk({tag, " scan_err"}, nsc - s0, r.sc);
        chk({tag, " digits"}, 32'(digits), 32'(r.dg));
        chk({tag, " locked"}, 32'(locked), 32'(r.lk));
    endtask

    initial begin
        // basic frame
        tbl.push_back(mk(4'hE, 7'h24, 8, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(4'h7, 7'h40, 8, 1, 1, 0, 0, 16'h0112, 1));
        // rotation: identical frame, then rotated frame
        tbl.push_back(mk(4'hE, 7'h24, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'h7, 7'h40, 8, 1, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'hE, 7'h40, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'hD, 7'h24, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h0112, 1));
        tbl.push_back(mk(4'h7, 7'h79, 8, 1, 1, 0, 0, 16'h1120, 1));
        // two anodes low, then illegal pattern; frame waits for a legal slot 0
        tbl.push_back(mk(4'hC, 7'h40, 8, 0, 0, 0, 1, 16'h1120, 1));
        tbl.push_back(mk(4'hE, 7'h7F, 8, 0, 0, 1, 0, 16'h1120, 1));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h1120, 1));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h1120, 1));
        tbl.push_back(mk(4'h7, 7'h79, 8, 0, 0, 0, 0, 16'h1120, 1));
        tbl.push_back(mk(4'hE, 7'h19, 8, 1, 1, 0, 0, 16'h1114, 1));
        // glitch filter: 2-cycle slot-0 spikes of "8" must not be captured
        tbl.push_back(mk(4'hE, 7'h40, 8, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hE, 7'h00, 2, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hE, 7'h00, 2, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h1114, 1));
        tbl.push_back(mk(4'h7, 7'h79, 8, 1, 1, 0, 0, 16'h1110, 1));
        // timeout on blank display, then the same frame re-locks with frame_changed
        tbl.push_back(mk(4'hF, 7'h7F, 90, 0, 0, 0, 0, 16'h1110, 1));
        tbl.push_back(mk(4'hF, 7'h7F, 20, 0, 0, 0, 0, 16'h1110, 0));
        tbl.push_back(mk(4'hE, 7'h40, 8, 0, 0, 0, 0, 16'h1110, 0));
        tbl.push_back(mk(4'hD, 7'h79, 8, 0, 0, 0, 0, 16'h1110, 0));
        tbl.push_back(mk(4'hB, 7'h79, 8, 0, 0, 0, 0, 16'h1110, 0));
        tbl.push_back(mk(4'h7, 7'h79, 8, 1, 1, 0, 0, 16'h1110, 1));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset digits", 32'(digits), 0);
        chk("reset frame_valid", 32'(frame_valid), 0);
        chk("reset frame_changed", 32'(frame_changed), 0);
        chk("reset locked", 32'(locked), 0);
        chk("reset seg_err", 32'(seg_err), 0);
        chk("reset scan_err", 32'(scan_err), 0);
        repeat (6) @(negedge clk);
        chk("idle no pulses", nfv + nse + nsc, 0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // reset mid-frame discards slots 0-2
        apply(mk(4'hE, 7'h24, 8, 0, 0, 0, 0, 16'h1110, 1), "mid s0");
        apply(mk(4'hD, 7'h24, 8, 0, 0, 0, 0, 16'h1110, 1), "mid s1");
        apply(mk(4'hB, 7'h24, 8, 0, 0, 0, 0, 16'h1110, 1), "mid s2");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst digits", 32'(digits), 0);
        chk("midrst locked", 32'(locked), 0);
        apply(mk(4'h7, 7'h19, 8, 0, 0, 0, 0, 16'h0000, 0), "post s3");
        apply(mk(4'hE, 7'h40, 8, 0, 0, 0, 0, 16'h0000, 0), "post s0");
        apply(mk(4'hD, 7'h40, 8, 0, 0, 0, 0, 16'h0000, 0), "post s1");
        apply(mk(4'hB, 7'h40, 8, 1, 1, 0, 0, 16'h4000, 1), "post s2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
